// File: rtl/collision_pkg.sv
// Shared types and helpers for the collision arbiter.
package collision_pkg;

    // Upper bounds for the helper functions and the channel state struct.
    localparam int MAX_OBJ  = 32;
    localparam int CD_MAX_W = 8;

    // Per-channel state: "already hit this frame" flag plus remaining cooldown frames.
    typedef struct packed {
        logic                flag;
        logic [CD_MAX_W-1:0] cooldown;
    } chan_state_t;

    // All-ones code of width idx_w, used as NO_HIT on hit_index.
    function automatic logic [31:0] no_hit_code(input int idx_w);
        return (32'd1 << idx_w) - 32'd1;
    endfunction

    function automatic int popcount(input logic [MAX_OBJ-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_OBJ; i++) n += int'(v[i]);
        return n;
    endfunction

    // Index of the lowest set bit, -1 when v is zero.
    function automatic int lowest_set(input logic [MAX_OBJ-1:0] v);
        for (int i = 0; i < MAX_OBJ; i++) if (v[i]) return i;
        return -1;
    endfunction

endpackage

// File: rtl/collision_channel.sv
// One collision channel: frame flag + cooldown counter and the hit decision.
module collision_channel
    import collision_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic sof,
    input  logic ov,
    output logic hit_next,
    output logic hit
);

    if (COOLDOWN_FRAMES < 0 || COOLDOWN_FRAMES >= (1 << CD_MAX_W)) begin : g_bad_cd
        $error("collision_channel: COOLDOWN_FRAMES out of range");
    end

    chan_state_t st, st_eff, st_nxt;

    // Frame start clears the flag and ages the cooldown before the overlap is judged.
    always_comb begin
        st_eff = st;
        if (sof) begin
            st_eff.flag = 1'b0;
            if (st.cooldown != '0) st_eff.cooldown = st.cooldown - CD_MAX_W'(1);
        end
        hit_next = ov && !st_eff.flag && (st_eff.cooldown == '0);
        st_nxt   = st_eff;
        if (hit_next) begin
            st_nxt.flag     = 1'b1;
            st_nxt.cooldown = CD_MAX_W'(COOLDOWN_FRAMES);
        end
    end

    // State and the single-cycle hit pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            st  <= '0;
            hit <= 1'b0;
        end else begin
            st  <= st_nxt;
            hit <= hit_next;
        end
    end

endmodule

// File: rtl/collision_arbiter_multi.sv
// Per-pixel collision arbiter: player vs border and N_OBJ object sprites.
module collision_arbiter_multi
    import collision_pkg::*;
#(
    parameter int N_OBJ           = 10,
    parameter int IDX_W           = 4,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             drawing_request_player,
    input  logic             drawing_request_border,
    input  logic [N_OBJ-1:0] drawing_request_obj,
    input  logic             clear_count,
    output logic             collision,
    output logic             border_pulse,
    output logic [N_OBJ-1:0] hit_pulse,
    output logic             hit_valid,
    output logic [IDX_W-1:0] hit_index,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [IDX_W-1:0] NO_HIT  = IDX_W'(no_hit_code(IDX_W));
    localparam int               CNT_MAX = (1 << CNT_W) - 1;

    if (N_OBJ > (1 << IDX_W) - 1) begin : g_bad_nobj
        $error("collision_arbiter_multi: N_OBJ exceeds 2^IDX_W-1");
    end
    if (N_OBJ < 1 || N_OBJ > MAX_OBJ) begin : g_bad_range
        $error("collision_arbiter_multi: N_OBJ out of supported range");
    end

    logic [N_OBJ-1:0] ov;
    logic [N_OBJ-1:0] hit_next;
    logic             ovb;
    logic             border_hit_unused;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;

    assign ov  = {N_OBJ{drawing_request_player}} & drawing_request_obj;
    assign ovb = drawing_request_player && drawing_request_border;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
        collision_channel #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_chan (
            .clk      (clk),
            .resetN   (resetN),
            .sof      (startOfFrame),
            .ov       (ov[g]),
            .hit_next (hit_next[g]),
            .hit      (hit_pulse[g])
        );
    end

    // The border only needs the once-per-frame flag, hence no cooldown.
    collision_channel #(.COOLDOWN_FRAMES(0)) u_border (
        .clk      (clk),
        .resetN   (resetN),
        .sof      (startOfFrame),
        .ov       (ovb),
        .hit_next (border_hit_unused),
        .hit      (border_pulse)
    );

    // Next index and saturating count from this cycle's new hits; clear wins over increment.
    always_comb begin
        int idx;
        int sum;
        idx     = lowest_set(MAX_OBJ'(hit_next));
        idx_nxt = (idx < 0) ? NO_HIT : IDX_W'(idx);
        sum     = int'(hit_count) + popcount(MAX_OBJ'(hit_next));
        cnt_nxt = (sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(sum);
        if (clear_count) cnt_nxt = '0;
    end

    // Registered summary outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collision <= 1'b0;
            hit_valid <= 1'b0;
            hit_index <= NO_HIT;
            hit_count <= '0;
        end else begin
            collision <= ovb || (|ov);
            hit_valid <= |hit_next;
            hit_index <= idx_nxt;
            hit_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_collision_arbiter_multi.sv
// Scoreboard bench for collision_arbiter_multi with a frame-number based reference model.
module tb_collision_arbiter_multi;

    localparam int N_OBJ = 10;
    localparam int IDX_W = 4;
    localparam int CD    = 2;
    localparam int CNT_W = 8;
    localparam int GAP   = (CD > 0) ? CD : 1;   // min frames between hits of one channel
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetN = 1'b0;
    logic             startOfFrame = 1'b0;
    logic             drawing_request_player = 1'b0;
    logic             drawing_request_border = 1'b0;
    logic [N_OBJ-1:0] drawing_request_obj = '0;
    logic             clear_count = 1'b0;
    logic             collision, border_pulse, hit_valid;
    logic [N_OBJ-1:0] hit_pulse;
    logic [IDX_W-1:0] hit_index;
    logic [CNT_W-1:0] hit_count;

    collision_arbiter_multi #(.N_OBJ(N_OBJ), .IDX_W(IDX_W), .COOLDOWN_FRAMES(CD), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .drawing_request_player(drawing_request_player),
        .drawing_request_border(drawing_request_border),
        .drawing_request_obj(drawing_request_obj), .clear_count(clear_count),
        .collision(collision), .border_pulse(border_pulse), .hit_pulse(hit_pulse),
        .hit_valid(hit_valid), .hit_index(hit_index), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             collision;
        logic             border_pulse;
        logic [N_OBJ-1:0] hit_pulse;
        logic             hit_valid;
        logic [IDX_W-1:0] hit_index;
        logic [CNT_W-1:0] hit_count;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a channel (objects 0..N_OBJ-1, border = N_OBJ) may hit when it
    // never hit since reset, or at least GAP frames have started since its last hit.
    int fnum = 0;
    bit ever[N_OBJ+1];
    int last[N_OBJ+1];
    int cnt = 0;

    task automatic drive(input bit sof, input bit pl, input bit bd,
                         input logic [N_OBJ-1:0] ob, input bit clr, input bit rn);
        exp_t e;
        int   nhits;
        @(negedge clk);
        resetN = rn; startOfFrame = sof; drawing_request_player = pl;
        drawing_request_border = bd; drawing_request_obj = ob; clear_count = clr;
        e = '0;
        e.hit_index = '1;
        if (!rn) begin
            fnum = 0; cnt = 0;
            for (int i = 0; i <= N_OBJ; i++) begin ever[i] = 0; last[i] = 0; end
        end else begin
            if (sof) fnum++;
            e.collision = pl && (bd || (ob != '0));
            nhits = 0;
            for (int i = 0; i <= N_OBJ; i++) begin
                bit ovl;
                ovl = pl && ((i == N_OBJ) ? bd : ob[i]);
                if (ovl && (!ever[i] || (fnum - last[i] >= ((i == N_OBJ) ? 1 : GAP)))) begin
                    ever[i] = 1; last[i] = fnum;
                    if (i == N_OBJ) e.border_pulse = 1'b1;
                    else begin
                        e.hit_pulse[i] = 1'b1;
                        if (nhits == 0) e.hit_index = IDX_W'(i);
                        nhits++;
                    end
                end
            end
            e.hit_valid = (nhits != 0);
            cnt = clr ? 0 : ((cnt + nhits > CMAX) ? CMAX : cnt + nhits);
        end
        e.hit_count = CNT_W'(cnt);
        q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a registered output set; compare with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({collision, border_pulse, hit_pulse, hit_valid, hit_index, hit_count} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got col=%b bp=%b hp=%h hv=%b idx=%0d cnt=%0d want col=%b bp=%b hp=%h hv=%b idx=%0d cnt=%0d",
                             $time, collision, border_pulse, hit_pulse, hit_valid, hit_index, hit_count,
                             e.collision, e.border_pulse, e.hit_pulse, e.hit_valid, e.hit_index, e.hit_count);
                end
            end
        end
    end

    localparam logic [N_OBJ-1:0] OBJ3   = N_OBJ'(1) << 3;
    localparam logic [N_OBJ-1:0] OBJ159 = (N_OBJ'(1) << 1) | (N_OBJ'(1) << 5) | (N_OBJ'(1) << 9);

    initial begin
        logic [N_OBJ-1:0] ob;
        int len;
        bit chaos;
        for (int i = 0; i <= N_OBJ; i++) begin ever[i] = 0; last[i] = 0; end
        // Reset state
        repeat (3) drive(0, 0, 0, '0, 0, 0);
        // Frame 0: obj3 overlaps for 50 pixels -> one pulse
        drive(1, 0, 0, '0, 0, 1);
        repeat (50) drive(0, 1, 0, OBJ3, 0, 1);
        repeat (3) drive(0, 0, 0, '0, 0, 1);
        // Frames 1..3: cooldown blocks frames 1 and 3
        for (int f = 1; f <= 3; f++) begin
            drive(1, 0, 0, '0, 0, 1);
            repeat (6) drive(0, 1, 0, OBJ3, 0, 1);
            drive(0, 0, 0, '0, 0, 1);
        end
        // Simultaneous hits on 1,5,9, then idle (NO_HIT)
        drive(1, 0, 0, '0, 0, 1);
        drive(0, 1, 0, OBJ159, 0, 1);
        drive(0, 0, 0, '0, 0, 1);
        // Border pulse once per frame; overlap coincident with startOfFrame
        repeat (3) drive(0, 1, 1, '0, 0, 1);
        drive(1, 1, 1, N_OBJ'(1), 0, 1);
        drive(1, 1, 1, N_OBJ'(1), 0, 1);
        // Clear coincident with a hit
        drive(1, 1, 0, N_OBJ'(4), 1, 1);
        // Reset mid-cooldown, then immediate hit in the next frame
        drive(1, 1, 0, OBJ3, 0, 1);
        drive(0, 0, 0, '0, 0, 1);
        drive(1, 0, 0, '0, 0, 1);
        drive(0, 1, 0, OBJ3, 0, 0);
        drive(0, 0, 0, '0, 0, 1);
        drive(1, 1, 0, OBJ3, 0, 1);
        drive(0, 0, 0, '0, 0, 1);
        // Random frames; later frames have no clear/reset so the counter saturates
        for (int f = 0; f < 360; f++) begin
            chaos = (f < 200);
            len = $urandom_range(6, 20);
            for (int c = 0; c < len; c++) begin
                for (int i = 0; i < N_OBJ; i++) ob[i] = ($urandom_range(0, 3) == 0);
                drive(c == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, ob,
                      chaos && ($urandom_range(0, 299) == 0),
                      !(chaos && ($urandom_range(0, 599) == 0)));
            end
        end
        drive(0, 0, 0, '0, 0, 1);
        // Drain: the queue must empty within a bounded number of cycles
        for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        if (cnt != CMAX) $display("note: counter ended at %0d (saturation not reached)", cnt);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_arbiter_multi.md
Name: collision_arbiter_multi

Overview:
Per-pixel collision arbiter between the player sprite, the border/brackets and up to N_OBJ independent object sprites.
- Generates at most one registered hit pulse per object per frame, and only when that object is outside its cooldown window.
- Reports the lowest-index hit and keeps a saturating hit counter.
- Sits between the sprite drawing-request muxes and the game-state/score logic.

Parameters:
N_OBJ, 10, number of object channels (1..2^IDX_W-1)
IDX_W, 4, width of hit_index; all-ones value is the NO_HIT code
COOLDOWN_FRAMES, 2, frames an object stays blocked after a hit (0 = no cooldown, hit once per frame only)
CNT_W, 8, width of hit_count

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous, active-low reset
startOfFrame  in  1  single-cycle pulse at start of each frame
drawing_request_player  in  1  player sprite pixel active
drawing_request_border  in  1  border/brackets pixel active
drawing_request_obj  in  N_OBJ  per-object pixel active
clear_count  in  1  synchronous clear of hit_count
collision  out  1  registered: player overlaps border or any object this pixel
border_pulse  out  1  one pulse per frame on first player/border overlap
hit_pulse  out  N_OBJ  per-object single hit pulse
hit_valid  out  1  OR of hit_pulse
hit_index  out  IDX_W  lowest set bit of hit_pulse, else NO_HIT
hit_count  out  CNT_W  saturating total of object hits

Behaviour:
- Reset values: collision=0, border_pulse=0, hit_pulse=0, hit_valid=0, hit_index=NO_HIT, hit_count=0. All per-channel flags=0 and cooldowns=0.
- Overlap (combinational):
  - ov[i] = player && obj[i]
  - ovb = player && border
- Latency: every output is registered, one clk after the pixel's requests.
- Per channel i, state = frame flag f[i] plus cooldown counter cd[i] (width clog2(COOLDOWN_FRAMES+1), min 1).
- Effective values in the current cycle:
  - f_eff = startOfFrame ? 0 : f[i]
  - cd_eff = (startOfFrame && cd[i]!=0) ? cd[i]-1 : cd[i]
- Hit condition: ov[i] && !f_eff && cd_eff==0 -> hit_pulse[i]=1 next cycle, f[i]<=1, cd[i]<=COOLDOWN_FRAMES.
- Otherwise f[i]<=f_eff and cd[i]<=cd_eff. A pulse therefore lasts exactly 1 cycle.
- startOfFrame coincident with an overlap: the clear and decrement apply first. The overlap then counts toward the new frame.
- Overlap with f=0 but cd_eff!=0: no pulse, f stays 0. The object can hit later in a frame where cd reaches 0.
- Border channel: same frame flag, no cooldown; drives border_pulse.
- Several objects hit in the same cycle:
  - all corresponding hit_pulse bits are set;
  - hit_index = lowest index;
  - hit_count += popcount(new pulses), saturating at 2^CNT_W-1 (no wrap).
- clear_count has priority over an increment in the same cycle: count becomes 0, and that cycle's hits are lost.
- collision = ovb || |ov, registered. It is independent of flags and cooldown.
- A reset asserted mid-frame or mid-cooldown returns everything to its reset values immediately. Next frame behaves as a fresh start.
- Elaboration check: $error if N_OBJ > 2^IDX_W-1.

Decomposition:
- Package collision_pkg: NO_HIT localparam function of IDX_W, popcount and lowest-set-bit functions, channel-state struct {flag, cooldown}.
- Sub-module collision_channel (parameter COOLDOWN_FRAMES): owns one flag+cooldown pair and its hit decision. The top instantiates N_OBJ of them via generate, plus one with COOLDOWN_FRAMES=0 for the border.

Test Plan:
- Single hit: obj[3] overlaps player for 50 consecutive pixels in frame 0 -> exactly one hit_pulse[3], 1 cycle after first overlap. hit_index=3, hit_count=1, collision high for 50 cycles.
- Cooldown (COOLDOWN_FRAMES=2): obj[3] overlaps in frames 0,1,2,3 -> pulses in frames 0 and 2 only, hit_count=2.
- Simultaneous: obj[1], obj[5], obj[9] overlap same pixel -> hit_pulse=bits{1,5,9}, hit_index=1, hit_count +=3. No overlap -> hit_index=15.
- Frame boundary: overlap on the same cycle as startOfFrame, after a hit earlier in the previous frame (COOLDOWN_FRAMES=0) -> new pulse next cycle.
- Saturation/clear (CNT_W=2): 5 hits -> hit_count=3. clear_count coincident with a hit -> hit_count=0.
- Reset mid-cooldown: resetN low during frame 1 after a frame-0 hit -> all outputs 0 and hit_index=NO_HIT. Overlap in the next frame pulses immediately.
